// File: rtl/toast_if_stage_pkg.sv
// Shared constants and helpers for the toast instruction-fetch stage.
package toast_if_stage_pkg;

  localparam int unsigned XLEN              = 32;
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_INCR           = 4;

  function automatic logic addr_misaligned(input logic [1:0] lsb);
    return |lsb;
  endfunction

endpackage

// File: rtl/toast_if_stage_if.sv
// Fetch-stage bus: control inputs, instruction memory port and decode-facing outputs.
interface toast_if_stage_if #(
  parameter int unsigned W = 32
) ();

  logic         stall_i;
  logic         flush_i;
  logic         branch_en_i;
  logic [W-1:0] branch_dest_i;
  logic [W-1:0] imem_rd_data_i;
  logic [W-1:0] IF_imem_addr_o;
  logic         IF_imem_rd_en_o;
  logic [W-1:0] IF_pc_o;
  logic [W-1:0] IF_instruction_o;
  logic         IF_misaligned_o;

  modport master (
    input  stall_i, flush_i, branch_en_i, branch_dest_i, imem_rd_data_i,
    output IF_imem_addr_o, IF_imem_rd_en_o, IF_pc_o, IF_instruction_o, IF_misaligned_o
  );

  modport slave (
    output stall_i, flush_i, branch_en_i, branch_dest_i, imem_rd_data_i,
    input  IF_imem_addr_o, IF_imem_rd_en_o, IF_pc_o, IF_instruction_o, IF_misaligned_o
  );

endinterface

// File: rtl/toast_if_stage_pc_gen.sv
// Program counter: redirect beats stall beats sequential increment; flags misaligned redirects.
module toast_pc_gen
  import toast_if_stage_pkg::*;
#(
  parameter int unsigned       W        = XLEN,
  parameter logic [W-1:0]      RESET_PC = DEFAULT_RESET_PC
) (
  input  logic         clk_i,
  input  logic         resetn_i,
  input  logic         stall_i,
  input  logic         branch_en_i,
  input  logic [W-1:0] branch_dest_i,
  output logic [W-1:0] pc_o,
  output logic         misaligned_o
);

  logic [W-1:0] pc_d, pc_q;
  logic         misaligned_d, misaligned_q;

  always_comb begin
    pc_d         = pc_q;
    misaligned_d = branch_en_i & addr_misaligned(branch_dest_i[1:0]);
    if (branch_en_i) begin
      pc_d = {branch_dest_i[W-1:2], 2'b00};
    end else if (stall_i) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_q + W'(PC_INCR);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      pc_q         <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign pc_o         = pc_q;
  assign misaligned_o = misaligned_q;

endmodule

// File: rtl/toast_if_stage.sv
// Instruction-fetch stage: issues fetches, squashes wrong-path returns and
// holds the presented instruction across decode stalls.
module toast_if_stage
  import toast_if_stage_pkg::*;
#(
  parameter int unsigned                REG_DATA_WIDTH = XLEN,
  parameter logic [REG_DATA_WIDTH-1:0]  RESET_PC       = DEFAULT_RESET_PC,
  parameter logic [REG_DATA_WIDTH-1:0]  NOP_INSTR      = DEFAULT_NOP_INSTR
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  toast_if_stage_if.master  bus
);

  localparam int unsigned W = REG_DATA_WIDTH;

  logic [W-1:0] pc_s;
  logic         misaligned_s;
  logic         rd_en_s;
  logic [W-1:0] fetch_pc_d, fetch_pc_q;
  logic [W-1:0] hold_d, hold_q;
  logic         hold_valid_d, hold_valid_q;
  logic         kill_d, kill_q;

  toast_pc_gen #(
    .W        (W),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk_i         (clk_i),
    .resetn_i      (resetn_i),
    .stall_i       (bus.stall_i),
    .branch_en_i   (bus.branch_en_i),
    .branch_dest_i (bus.branch_dest_i),
    .pc_o          (pc_s),
    .misaligned_o  (misaligned_s)
  );

  assign rd_en_s = resetn_i & (~bus.stall_i | bus.branch_en_i);

  // Capture the presented word on the first live stall cycle so a stalled
  // decode sees it unchanged even though the memory is not re-read.
  always_comb begin
    fetch_pc_d   = rd_en_s ? pc_s : fetch_pc_q;
    kill_d       = bus.branch_en_i | bus.flush_i;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (bus.flush_i || bus.branch_en_i) begin
      hold_valid_d = 1'b0;
    end else if (!bus.stall_i) begin
      hold_valid_d = 1'b0;
    end else if (!hold_valid_q && !kill_q) begin
      hold_d       = bus.imem_rd_data_i;
      hold_valid_d = 1'b1;
    end else begin
      hold_valid_d = hold_valid_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      fetch_pc_q   <= '0;
      kill_q       <= 1'b1;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      kill_q       <= kill_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  always_comb begin
    bus.IF_pc_o          = fetch_pc_q;
    bus.IF_instruction_o = bus.imem_rd_data_i;
    if (kill_q) begin
      bus.IF_pc_o          = '0;
      bus.IF_instruction_o = NOP_INSTR;
    end else if (hold_valid_q) begin
      bus.IF_instruction_o = hold_q;
    end else begin
      bus.IF_instruction_o = bus.imem_rd_data_i;
    end
  end

  assign bus.IF_imem_addr_o  = pc_s;
  assign bus.IF_imem_rd_en_o = rd_en_s;
  assign bus.IF_misaligned_o = misaligned_s;

endmodule

// File: tb/tb_toast_if_stage.sv
// Self-checking bench for toast_if_stage: directed vector table, hand-written
// reset/flush sequences, then constrained-random traffic against a stream model.
module tb_toast_if_stage;
  import toast_if_stage_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    bit          st;
    bit          fl;
    bit          br;
    logic [31:0] dst;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    bit          e_mis;
  } vec_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  toast_if_stage_if #(.W(32)) bus ();

  toast_if_stage dut (
    .clk_i    (clk),
    .resetn_i (resetn),
    .bus      (bus)
  );

  // Memory returns addr|0xA000_0000 one cycle after a read; garbage otherwise.
  always @(posedge clk) begin
    if (bus.IF_imem_rd_en_o) bus.imem_rd_data_i <= bus.IF_imem_addr_o | 32'hA000_0000;
    else                     bus.imem_rd_data_i <= $urandom;
  end

  // Stream model: what decode should see is the word of the latest issued
  // fetch, except for one bubble after any redirect, flush or reset.
  logic [31:0] m_pc;
  logic [31:0] m_last;
  bit          m_bubble;
  bit          m_mis;
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a | 32'hA000_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic cycle(input bit st, input bit fl, input bit br, input logic [31:0] dst,
                       output logic [31:0] o_pc, output logic [31:0] o_ins, output bit o_mis);
    bit exp_rd;
    @(negedge clk);
    resetn            = 1'b1;
    bus.stall_i       = st;
    bus.flush_i       = fl;
    bus.branch_en_i   = br;
    bus.branch_dest_i = dst;
    #1;
    exp_rd = !st || br;
    chk("rd_en", {31'd0, bus.IF_imem_rd_en_o}, {31'd0, exp_rd});
    chk("imem_addr", bus.IF_imem_addr_o, m_pc);
    chk("pc", bus.IF_pc_o, m_bubble ? 32'h0 : m_last);
    chk("instr", bus.IF_instruction_o, m_bubble ? NOP : mem_word(m_last));
    chk("misaligned", {31'd0, bus.IF_misaligned_o}, {31'd0, m_mis});
    o_pc  = bus.IF_pc_o;
    o_ins = bus.IF_instruction_o;
    o_mis = bus.IF_misaligned_o;
    @(posedge clk);
    if (exp_rd) m_last = m_pc;
    m_mis    = br && (dst % 4 != 0);
    m_pc     = br ? dst - (dst % 4) : (st ? m_pc : m_pc + 32'd4);
    m_bubble = br || fl;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    resetn            = 1'b0;
    bus.stall_i       = 1'b0;
    bus.flush_i       = 1'b0;
    bus.branch_en_i   = 1'b0;
    bus.branch_dest_i = 32'h0;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("rd_en_in_reset", {31'd0, bus.IF_imem_rd_en_o}, 32'd0);
      @(posedge clk);
    end
    m_pc     = 32'h0;
    m_last   = 32'h0;
    m_bubble = 1'b1;
    m_mis    = 1'b0;
  endtask

  vec_t        tbl [22];
  logic [31:0] r_pc, r_ins;
  bit          r_mis;

  initial begin
    bit st, fl, br, prev_kill, prev_st;
    logic [31:0] dst;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         NOP,           1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'hA000_0000, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h4,         32'hA000_0004, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h8,         32'hA000_0008, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h8,         32'hA000_0008, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h8,         32'hA000_0008, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h8,         32'hA000_0008, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'h100,       32'hC,         32'hA000_000C, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         NOP,           1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h100,       32'hA000_0100, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 32'h40,        32'h104,       32'hA000_0104, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         NOP,           1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h40,        32'hA000_0040, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h44,        32'hA000_0044, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         NOP,           1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 32'h102,       32'h4C,        32'hA000_004C, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         NOP,           1'b1};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h100,       32'hA000_0100, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h104,       32'hA000_0104, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         NOP,           1'b0};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'hA000_0000, 1'b0};

    do_reset(2);
    for (int i = 0; i < 22; i++) begin
      cycle(tbl[i].st, tbl[i].fl, tbl[i].br, tbl[i].dst, r_pc, r_ins, r_mis);
      chk($sformatf("vec%0d_pc", i), r_pc, tbl[i].e_pc);
      chk($sformatf("vec%0d_instr", i), r_ins, tbl[i].e_ins);
      chk($sformatf("vec%0d_mis", i), {31'd0, r_mis}, {31'd0, tbl[i].e_mis});
    end

    // Reset while stalled with a redirect pending: all state discarded.
    cycle(1'b1, 1'b0, 1'b0, 32'h0, r_pc, r_ins, r_mis);
    cycle(1'b1, 1'b0, 1'b1, 32'h200, r_pc, r_ins, r_mis);
    do_reset(1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, r_pc, r_ins, r_mis);
    chk("rst_mid_bubble_pc", r_pc, 32'h0);
    chk("rst_mid_bubble_instr", r_ins, NOP);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, r_pc, r_ins, r_mis);
    chk("rst_mid_first_instr", r_ins, 32'hA000_0000);

    // Flush during a stall: one bubble, pc held, then the held pc is fetched.
    cycle(1'b1, 1'b0, 1'b0, 32'h0, r_pc, r_ins, r_mis);
    chk("fl_st_pres_pc", r_pc, 32'h4);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, r_pc, r_ins, r_mis);
    chk("fl_st_hold_instr", r_ins, 32'hA000_0004);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, r_pc, r_ins, r_mis);
    chk("fl_st_bubble", r_ins, NOP);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, r_pc, r_ins, r_mis);
    chk("fl_st_resume_pc", r_pc, 32'h8);
    chk("fl_st_resume_instr", r_ins, 32'hA000_0008);

    // Random traffic; no stall in the cycle right after a bubble-causing event.
    prev_kill = 1'b0;
    prev_st   = 1'b0;
    for (int i = 0; i < 600; i++) begin
      st  = !prev_kill && (prev_st ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
      fl  = ($urandom_range(0, 9) == 0);
      br  = ($urandom_range(0, 7) == 0);
      dst = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
      cycle(st, fl, br, dst, r_pc, r_ins, r_mis);
      prev_kill = br || fl;
      prev_st   = st;
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1);
        prev_kill = 1'b1;
        prev_st   = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
